// File: rtl/ddr4_wr_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : ddr4_wr_ctrl_if
// Brief    : MIG user-interface write command/data bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ddr4_wr_ctrl_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 512
);
    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [ADDR_W-1:0]     app_addr;
    logic                  app_rdy;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [DATA_W-1:0]     app_wdf_data;
    logic [DATA_W/8-1:0]   app_wdf_mask;
    logic                  app_wdf_rdy;

    modport master (
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy
    );

    modport slave (
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy
    );
endinterface

`default_nettype wire

// File: rtl/ddr4_wr_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ddr4_wr_ctrl
// Brief    : Moves one BURST_LEN-beat burst from a FWFT FIFO into the MIG per start pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr4_wr_ctrl #(
    parameter int ADDR_W      = 29,
    parameter int DATA_W      = 512,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_STEP   = 8,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 1920*1080*4/64
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                init_calib_complete,
    input  wire                wr_cmd_start,
    output logic               wr_end,
    output logic               wr_fifo_rd_en,
    input  wire [DATA_W-1:0]   wr_fifo_dout,
    output logic               busy,
    ddr4_wr_ctrl_if.master     app
);

    localparam int                CNT_W   = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  c_BURST = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(BASE_ADDR + (FRAME_WORDS - 1) * ADDR_STEP);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_CAL = 2'd1,
        S_WRITE    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cmd_cnt;
    logic [CNT_W-1:0]   r_dat_cnt;
    logic [CNT_W-1:0]   w_cmd_cnt_nxt;
    logic [CNT_W-1:0]   w_dat_cnt_nxt;
    logic [ADDR_W-1:0]  r_app_addr;
    logic               w_app_en;
    logic               w_wdf_wren;
    logic               w_cmd_acc;
    logic               w_dat_acc;

    assign w_app_en      = (r_state == S_WRITE) && (r_cmd_cnt < c_BURST);
    assign w_wdf_wren    = (r_state == S_WRITE) && (r_dat_cnt < c_BURST);
    assign w_cmd_acc     = w_app_en && app.app_rdy;
    assign w_dat_acc     = w_wdf_wren && app.app_wdf_rdy;
    assign w_cmd_cnt_nxt = r_cmd_cnt + CNT_W'(w_cmd_acc);
    assign w_dat_cnt_nxt = r_dat_cnt + CNT_W'(w_dat_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion looks at the post-accept counts so DONE lands the cycle after the final beat/command.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (wr_cmd_start) begin
                    w_state_nxt = init_calib_complete ? S_WRITE : S_WAIT_CAL;
                end
            end
            S_WAIT_CAL: begin
                if (init_calib_complete) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if ((w_cmd_cnt_nxt == c_BURST) && (w_dat_cnt_nxt == c_BURST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_cnt  <= '0;
            r_dat_cnt  <= '0;
            r_app_addr <= c_BASE;
        end else begin
            if ((w_state_nxt == S_WRITE) && (r_state != S_WRITE)) begin
                r_cmd_cnt <= '0;
                r_dat_cnt <= '0;
            end else begin
                r_cmd_cnt <= w_cmd_cnt_nxt;
                r_dat_cnt <= w_dat_cnt_nxt;
            end
            // Address survives across bursts and wraps at the last word of the frame.
            if (w_cmd_acc) begin
                r_app_addr <= (r_app_addr == c_LAST) ? c_BASE : (r_app_addr + c_STEP);
            end
        end
    end

    assign app.app_en       = w_app_en;
    assign app.app_cmd      = 3'b000;
    assign app.app_addr     = r_app_addr;
    assign app.app_wdf_wren = w_wdf_wren;
    assign app.app_wdf_end  = w_wdf_wren;
    assign app.app_wdf_data = wr_fifo_dout;
    assign app.app_wdf_mask = '0;

    assign wr_fifo_rd_en = w_dat_acc;
    assign wr_end        = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire
